uart_rx_tx_fifo: RTL

- Buffering stage between the UART receive and transmit paths of the UART top level.
- Consumes received bytes (rx_data qualified by the rx_done pulse) into a circular FIFO.
- Drains the FIFO into the transmitter through a level tx_start / tx_busy handshake, which gives the echo/loopback path for the FIFO testbench.
- Decouples receive bursts from transmit pacing and flags bytes dropped on overflow.

---
 rtl/uart_rx_tx_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_rx_tx_fifo.sv
// Circular byte FIFO between the UART receiver and transmitter: pushes on rx_done,
// drains into the Tx stage through a level tx_start / tx_busy handshake.
module uart_rx_tx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLaunch, StDrain} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q;
  logic              push, pop;

  // full/empty come from the registered count, so a push at full is dropped
  // even when the FSM pops on the same edge.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign push  = rx_done && !full;

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = mem_q[rptr_q];
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        // No timeout: the transmitter may acknowledge on its own bit tick.
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (!tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= rx_done && full;
      if (push) begin
        wptr_q <= wptr_q + PtrOne;
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
    end
  end

  // Storage has no reset; contents are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= rx_data;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
